linear_image_filter_udiv_64ns_32ns_32_seq: RTL

//   Sequential unsigned divider: 64-bit dividend / 32-bit divisor -> 32-bit quotient + 32-bit remainder.

---
 rtl/linear_image_filter_pkg.sv | 19 +
 rtl/linear_image_filter_udiv_step.sv | 27 ++
 rtl/linear_image_filter_udiv_64ns_32ns_32_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/linear_image_filter_pkg.sv
// Shared types and constants for the linear image filter datapath blocks.
// The divider uses them for its state encoding, widths and saturation value.
package linear_image_filter_pkg;

    localparam int DIV_W      = 32;
    localparam int DIVIDEND_W = 64;
    localparam int CNT_W      = $clog2(DIV_W);

    localparam logic [DIV_W-1:0] DIV_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef logic [CNT_W-1:0] div_cnt_t;

endpackage

// File: rtl/linear_image_filter_udiv_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it did not borrow.
module linear_image_filter_udiv_step
    import linear_image_filter_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] r,
    input  logic         q_msb,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The partial remainder is always below the divisor, so after either
    // outcome its top bit is zero and W bits are enough to hold it.
    always_comb begin
        shifted = {r, q_msb};
        diff    = shifted - {1'b0, d};
        q_bit   = ~diff[W];
        r_next  = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/linear_image_filter_udiv_64ns_32ns_32_seq.sv
// Sequential 64/32 unsigned divider, one quotient bit per enabled cycle,
// with start/done handshake, clock enable and divide-by-zero/overflow flags.
module linear_image_filter_udiv_64ns_32ns_32_seq
    import linear_image_filter_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 32,
    parameter int din0_WIDTH = 64,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  dbz,
    output logic                  ovf
);

    if (NUM_STAGE != dout_WIDTH || dout_WIDTH != DIV_W ||
        din0_WIDTH != din1_WIDTH + dout_WIDTH) begin : g_cfg_err
        $error("udiv instance %0d: inconsistent width parameters", ID);
    end

    localparam div_cnt_t LAST_CNT = div_cnt_t'(NUM_STAGE - 1);

    div_state_t            state_q, state_d;
    div_cnt_t              cnt_q, cnt_d;
    logic [din1_WIDTH-1:0] r_q, r_d;
    logic [dout_WIDTH-1:0] q_q, q_d;
    logic [din1_WIDTH-1:0] dsr_q, dsr_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [din1_WIDTH-1:0] rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    logic                  accept;
    logic [din1_WIDTH-1:0] dividend_hi;
    logic [din1_WIDTH-1:0] step_r;
    logic                  step_qbit;

    assign dividend_hi = din0[din0_WIDTH-1:dout_WIDTH];

    linear_image_filter_udiv_step #(
        .W(din1_WIDTH)
    ) u_step (
        .r     (r_q),
        .q_msb (q_q[dout_WIDTH-1]),
        .d     (dsr_q),
        .r_next(step_r),
        .q_bit (step_qbit)
    );

    always_comb begin
        // NOTE: every next-state value defaults to its current value before any branch, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dsr_d   = dsr_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        accept = ce && start && !busy_q;

        if (accept) begin
            r_d    = dividend_hi;
            q_d    = din0[dout_WIDTH-1:0];
            dsr_d  = din1;
            cnt_d  = '0;
            done_d = 1'b0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
            if (din1 == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
                dout_d  = DIV_SAT;
                rem_d   = din0[din1_WIDTH-1:0];
            end else if (dividend_hi >= din1) begin
                // Quotient would not fit in dout_WIDTH bits.
                state_d = DONE;
                done_d  = 1'b1;
                ovf_d   = 1'b1;
                dout_d  = DIV_SAT;
                rem_d   = '0;
            end else begin
                state_d = CALC;
            end
        end else if (ce) begin
            case (state_q)
                CALC: begin
                    r_d   = step_r;
                    q_d   = {q_q[dout_WIDTH-2:0], step_qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        dout_d  = q_d;
                        rem_d   = step_r;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
                default: ;
            endcase
        end

        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dsr_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop load from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dsr_q   <= dsr_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule
